// File: rtl/vec_addsub_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : vec_addsub_fifo_if
// Brief    : Operand pop / result FIFO bundle for vec_addsub_fifo.
// Revision : 1.0 - initial release
// ============================================================================
interface vec_addsub_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 3,
  parameter int FIFO_DEPTH = 16
);
  localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic signed [DATA_WIDTH-1:0] x   [LANES-1:0];
  logic signed [DATA_WIDTH-1:0] y   [LANES-1:0];
  logic                         op;
  logic                         in_empty;
  logic                         in_rd_en;
  logic signed [DATA_WIDTH-1:0] out [LANES-1:0];
  logic                         ovf;
  logic                         out_empty;
  logic                         out_rd_en;
  logic [c_CNT_W-1:0]           out_count;

  // Drives operands and pops results.
  modport master (
    output x, y, op, in_empty, out_rd_en,
    input  in_rd_en, out, ovf, out_empty, out_count
  );

  // The add/sub stage itself.
  modport slave (
    input  x, y, op, in_empty, out_rd_en,
    output in_rd_en, out, ovf, out_empty, out_count
  );
endinterface
`default_nettype wire

// File: rtl/vec_addsub_fifo.sv
`default_nettype none
// ============================================================================
// Module   : vec_addsub_fifo
// Brief    : Lane-wise signed add/sub, 2-stage pipeline into an FWFT FIFO.
//            Define VEC_ADDSUB_SAT_EN to saturate overflowing lanes.
// Revision : 1.0 - initial release
// ============================================================================
module vec_addsub_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 3,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clock,
  input  logic              reset,
  vec_addsub_fifo_if.slave  bus
);
  localparam int c_ADDR_W = $clog2(FIFO_DEPTH);
  localparam int c_PTR_W  = c_ADDR_W + 1;
  localparam logic [c_PTR_W:0] c_DEPTH = (c_PTR_W + 1)'(FIFO_DEPTH);

  typedef logic signed [DATA_WIDTH-1:0] lane_t;

`ifdef VEC_ADDSUB_SAT_EN
  localparam lane_t c_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam lane_t c_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
`endif

  lane_t                 res_d [LANES];
  lane_t                 res_q [LANES];
  logic                  ovf_d, ovf_q;
  logic                  valid_d, valid_q;
  logic [c_PTR_W-1:0]    wr_ptr_d, wr_ptr_q;
  logic [c_PTR_W-1:0]    rd_ptr_d, rd_ptr_q;

  lane_t                 mem_res [FIFO_DEPTH][LANES];
  logic                  mem_ovf [FIFO_DEPTH];

  logic [DATA_WIDTH:0]   w_sum      [LANES];
  logic                  w_lane_ovf [LANES];
  logic [c_PTR_W-1:0]    w_count;
  logic [c_PTR_W:0]      w_credits;
  logic                  w_empty;
  logic                  w_issue;
  logic                  w_pop;
  logic [c_ADDR_W-1:0]   w_rd_addr;
  logic [c_ADDR_W-1:0]   w_wr_addr;

  // Stage 0: one extra bit of headroom exposes signed overflow.
  always_comb begin
    ovf_d = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (bus.op)
        w_sum[i] = {bus.x[i][DATA_WIDTH-1], bus.x[i]} - {bus.y[i][DATA_WIDTH-1], bus.y[i]};
      else
        w_sum[i] = {bus.x[i][DATA_WIDTH-1], bus.x[i]} + {bus.y[i][DATA_WIDTH-1], bus.y[i]};
      w_lane_ovf[i] = w_sum[i][DATA_WIDTH] ^ w_sum[i][DATA_WIDTH-1];
      ovf_d         = ovf_d | w_lane_ovf[i];
`ifdef VEC_ADDSUB_SAT_EN
      if (w_lane_ovf[i])
        res_d[i] = w_sum[i][DATA_WIDTH] ? c_MIN : c_MAX;
      else
        res_d[i] = w_sum[i][DATA_WIDTH-1:0];
`else
      res_d[i] = w_sum[i][DATA_WIDTH-1:0];
`endif
    end
  end

  // Credits count both buffered entries and the stage-1 entry already
  // committed to a slot, so stage 1 never needs backpressure.
  always_comb begin
    w_count   = wr_ptr_q - rd_ptr_q;
    w_empty   = (wr_ptr_q == rd_ptr_q);
    w_credits = {1'b0, w_count} + {{c_PTR_W{1'b0}}, valid_q};
    w_issue   = !reset && !bus.in_empty && (w_credits < c_DEPTH);
    w_pop     = bus.out_rd_en && !w_empty;
    w_rd_addr = rd_ptr_q[c_ADDR_W-1:0];
    w_wr_addr = wr_ptr_q[c_ADDR_W-1:0];
    valid_d   = w_issue;
    wr_ptr_d  = valid_q ? wr_ptr_q + c_PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = w_pop   ? rd_ptr_q + c_PTR_W'(1) : rd_ptr_q;
  end

  always_comb begin
    for (int i = 0; i < LANES; i++)
      bus.out[i] = w_empty ? lane_t'(0) : mem_res[w_rd_addr][i];
    bus.ovf       = !w_empty && mem_ovf[w_rd_addr];
    bus.out_empty = w_empty;
    bus.out_count = w_count;
    bus.in_rd_en  = w_issue;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Payload storage needs no reset: empty pointers mask every stale slot.
  always_ff @(posedge clock) begin
    ovf_q <= ovf_d;
    for (int i = 0; i < LANES; i++)
      res_q[i] <= res_d[i];
    if (valid_q) begin
      mem_ovf[w_wr_addr] <= ovf_q;
      for (int i = 0; i < LANES; i++)
        mem_res[w_wr_addr][i] <= res_q[i];
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_vec_addsub_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_vec_addsub_fifo
// Brief    : Scoreboard bench for vec_addsub_fifo against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vec_addsub_fifo;
  localparam int DW         = 32;
  localparam int LANES      = 3;
  localparam int FIFO_DEPTH = 16;
  localparam int WB         = LANES * DW + 1;

  typedef logic [LANES*DW-1:0] vec_t;
  typedef struct packed { vec_t x; vec_t y; logic op; } stim_t;
  typedef struct packed { vec_t d; logic o; } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vec_addsub_fifo_if #(.DATA_WIDTH(DW), .LANES(LANES), .FIFO_DEPTH(FIFO_DEPTH)) bus ();
  vec_addsub_fifo #(.DATA_WIDTH(DW), .LANES(LANES), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus)
  );

  stim_t up_q [$];
  exp_t  sb   [$];
  int    tests   = 0;
  int    fails   = 0;
  int    n_issue = 0;
  bit    rst_req = 1'b1;
  bit    gap_en  = 1'b0;
  int    rd_mode = 0;

  task automatic chk(input string nm, input logic [WB-1:0] act, input logic [WB-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Exact integer arithmetic, then wrap or clamp to the lane width.
  function automatic exp_t model(input stim_t s);
    exp_t   e;
    longint a, b, r, mx, mn;
    mx  = (longint'(1) <<< (DW - 1)) - 1;
    mn  = -(longint'(1) <<< (DW - 1));
    e.o = 1'b0;
    e.d = '0;
    for (int i = 0; i < LANES; i++) begin
      a = longint'($signed(s.x[i*DW +: DW]));
      b = longint'($signed(s.y[i*DW +: DW]));
      r = s.op ? a - b : a + b;
      if (r > mx || r < mn) begin
        e.o = 1'b1;
`ifdef VEC_ADDSUB_SAT_EN
        r = (r > mx) ? mx : mn;
`endif
      end
      e.d[i*DW +: DW] = r[DW-1:0];
    end
    return e;
  endfunction

  function automatic logic [DW-1:0] rand_lane();
    logic [DW-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = {1'b0, {(DW-1){1'b1}}};
      1:       v = {1'b1, {(DW-1){1'b0}}};
      2:       v = '1;
      3:       v = DW'($urandom_range(0, 20));
      default: v = DW'($urandom);
    endcase
    return v;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    for (int i = 0; i < LANES; i++) begin
      s.x[i*DW +: DW] = rand_lane();
      s.y[i*DW +: DW] = rand_lane();
    end
    s.op = 1'($urandom_range(0, 1));
    return s;
  endfunction

  function automatic vec_t flat_out();
    vec_t f;
    for (int i = 0; i < LANES; i++) f[i*DW +: DW] = bus.out[i];
    return f;
  endfunction

  function automatic logic [DW-1:0] lane(input int i);
    return bus.out[i];
  endfunction

  task automatic drive();
    reset = rst_req;
    if (rst_req) sb.delete();
    bus.in_empty = (up_q.size() == 0) || (gap_en && $urandom_range(0, 3) == 0);
    if (up_q.size() > 0) begin
      for (int i = 0; i < LANES; i++) begin
        bus.x[i] = up_q[0].x[i*DW +: DW];
        bus.y[i] = up_q[0].y[i*DW +: DW];
      end
      bus.op = up_q[0].op;
    end
    case (rd_mode)
      0:       bus.out_rd_en = 1'b0;
      1:       bus.out_rd_en = 1'b1;
      default: bus.out_rd_en = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic sample();
    @(negedge clk);
    if (reset || bus.in_empty)
      chk("rd_en_blocked", WB'(bus.in_rd_en), '0);
    else if (bus.in_rd_en) begin
      sb.push_back(model(up_q[0]));
      void'(up_q.pop_front());
      n_issue++;
    end
  endtask

  task automatic cycle();
    adv();
    sample();
  endtask

  task automatic pop_one();
    rd_mode = 1;
    adv();
    rd_mode = 0;
    sample();
  endtask

  task automatic drain();
    int k;
    rd_mode = 1;
    gap_en  = 1'b0;
    k       = 0;
    while ((up_q.size() > 0 || sb.size() > 0) && k < 1000) begin
      cycle();
      k++;
    end
    chk("drain_bound", WB'(sb.size() + up_q.size()), '0);
    cycle();
    chk("drained_empty", WB'(bus.out_empty), WB'(1'b1));
    rd_mode = 0;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.out_empty)
        chk("empty_out_zero", {bus.ovf, flat_out()}, '0);
      else if (bus.out_rd_en) begin
        if (sb.size() == 0)
          chk("unexpected_output", {bus.ovf, flat_out()}, '0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_data", WB'(flat_out()), WB'(e.d));
          chk("out_ovf", WB'(bus.ovf), WB'(e.o));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    int    base;
    int    k;
`ifdef VEC_ADDSUB_SAT_EN
    logic [DW-1:0] sub_lane0 = 32'h7FFF_FFFF;
`else
    logic [DW-1:0] sub_lane0 = 32'h8000_0000;
`endif
    reset         = 1'b1;
    bus.in_empty  = 1'b1;
    bus.out_rd_en = 1'b0;
    bus.op        = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      bus.x[i] = '0;
      bus.y[i] = '0;
    end

    // Reset with a vector already waiting upstream.
    s.x  = {DW'(100), DW'(-2), DW'(1)};
    s.y  = {DW'(-100), DW'(5), DW'(3)};
    s.op = 1'b0;
    up_q.push_back(s);
    repeat (3) begin
      cycle();
      chk("rst_out_empty", WB'(bus.out_empty), WB'(1'b1));
      chk("rst_out_count", WB'(bus.out_count), '0);
      chk("rst_out_ovf", {bus.ovf, flat_out()}, '0);
    end

    // Single add and its two-cycle latency.
    rst_req = 1'b0;
    cycle();
    chk("resume_rd_en", WB'(bus.in_rd_en), WB'(1'b1));
    chk("lat_n0_empty", WB'(bus.out_empty), WB'(1'b1));
    cycle();
    chk("lat_n1_empty", WB'(bus.out_empty), WB'(1'b1));
    cycle();
    chk("lat_n2_empty", WB'(bus.out_empty), '0);
    chk("add_lane0", WB'(lane(0)), WB'(DW'(4)));
    chk("add_lane1", WB'(lane(1)), WB'(DW'(3)));
    chk("add_lane2", WB'(lane(2)), '0);
    chk("add_ovf", WB'(bus.ovf), '0);
    pop_one();

    // Subtract overflowing on lane 0.
    s.x  = {DW'(0), DW'(5), 32'h7FFF_FFFF};
    s.y  = {DW'(0), DW'(7), 32'hFFFF_FFFF};
    s.op = 1'b1;
    up_q.push_back(s);
    k = 0;
    do begin
      cycle();
      k++;
    end while (bus.out_empty && k < 8);
    chk("sub_seen", WB'(bus.out_empty), '0);
    chk("sub_lane0", WB'(lane(0)), WB'(sub_lane0));
    chk("sub_lane1", WB'(lane(1)), WB'(32'hFFFF_FFFE));
    chk("sub_ovf", WB'(bus.ovf), WB'(1'b1));
    pop_one();
    cycle();

    // Back-to-back stream with the consumer always ready.
    rd_mode = 1;
    repeat (40) up_q.push_back(rand_stim());
    k = 0;
    while (up_q.size() > 0 && k < 80) begin
      cycle();
      k++;
      chk("stream_rd_en", WB'(bus.in_rd_en), WB'(1'b1));
      chk("stream_cnt_le2", WB'(bus.out_count <= 2), WB'(1'b1));
    end
    drain();

    // Fill with no reads, then release one credit.
    rd_mode = 0;
    repeat (30) up_q.push_back(rand_stim());
    base = n_issue;
    repeat (25) cycle();
    chk("fill_pops", WB'(n_issue - base), WB'(FIFO_DEPTH));
    chk("fill_rd_en_low", WB'(bus.in_rd_en), '0);
    chk("fill_count", WB'(bus.out_count), WB'(FIFO_DEPTH));
    pop_one();
    chk("credit_same_cycle", WB'(bus.in_rd_en), '0);
    cycle();
    chk("credit_next_cycle", WB'(bus.in_rd_en), WB'(1'b1));
    chk("credit_one_pop", WB'(n_issue - base), WB'(FIFO_DEPTH + 1));
    pop_one();
    chk("credit_relock", WB'(bus.in_rd_en), '0);
    chk("pushpop_before", WB'(bus.out_count), WB'(FIFO_DEPTH - 1));
    cycle();
    chk("pushpop_after", WB'(bus.out_count), WB'(FIFO_DEPTH - 1));
    drain();

    // Reset with five buffered and one in flight.
    repeat (10) up_q.push_back(rand_stim());
    base = n_issue;
    k    = 0;
    while (n_issue - base < 6 && k < 20) begin
      cycle();
      k++;
    end
    rst_req = 1'b1;
    cycle();
    chk("rst_mid_rd_en", WB'(bus.in_rd_en), '0);
    chk("rst_mid_setup", WB'(bus.out_count), WB'(5));
    rst_req = 1'b0;
    cycle();
    chk("rst_mid_empty", WB'(bus.out_empty), WB'(1'b1));
    chk("rst_mid_count", WB'(bus.out_count), '0);
    chk("rst_mid_out", {bus.ovf, flat_out()}, '0);
    chk("rst_mid_resume", WB'(bus.in_rd_en), WB'(1'b1));
    drain();

    // Random traffic with upstream gaps and a sporadic consumer.
    gap_en  = 1'b1;
    rd_mode = 2;
    repeat (400) begin
      if (up_q.size() < 6 && $urandom_range(0, 1) == 1) up_q.push_back(rand_stim());
      cycle();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/vec_addsub_fifo.md
# vec_addsub_fifo

Parametrised, fully pipelined lane-wise signed adder/subtractor with an integrated first-word-fall-through output FIFO. It is the next-generation vector add stage for the ray-tracer math pipeline, with configurable lane count, data width and buffer depth. It adds a per-transaction add/subtract mode and an overflow flag, and sustains one vector per clock, where the previous stage accepted one every two cycles. It sits between an upstream FWFT FIFO (x, y, op) and any downstream fifo_math consumer.

## Interface
- DATA_WIDTH, 32, bits per lane (signed two's complement)
- LANES, 3, number of vector lanes
- FIFO_DEPTH, 16, output FIFO entries; power of two, ≥ 4
- clock  in  1  single clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- x  in  LANES×DATA_WIDTH  operand A, unpacked array [LANES-1:0], valid while !in_empty
- y  in  LANES×DATA_WIDTH  operand B, same shape as x
- op  in  1  0 = x+y, 1 = x−y; travels with x/y
- in_empty  in  1  upstream FIFO empty
- in_rd_en  out  1  pop upstream; combinational
- out  out  LANES×DATA_WIDTH  FIFO head result; forced 0 while out_empty
- ovf  out  1  head entry: OR of per-lane signed overflow; forced 0 while out_empty
- out_empty  out  1  output FIFO empty
- out_rd_en  in  1  pop output FIFO head
- out_count  out  $clog2(FIFO_DEPTH)+1  entries currently in output FIFO

## Operation
- Credit counter `credits` = out_count + stage-1 valid. Issue condition: !reset && !in_empty && credits < FIFO_DEPTH → in_rd_en = 1.
- Stage 0 (issue cycle): per lane r[i] = op ? x[i]−y[i] : x[i]+y[i], computed at DATA_WIDTH+1 bits. Overflow on lane i when bit DATA_WIDTH ≠ bit DATA_WIDTH−1 of the result. Result, ovf and valid are registered into stage 1.
- Stage 1: when valid, write {result, ovf} into FIFO at wr_ptr. No backpressure is needed because the credit check guarantees space.
- FIFO: FWFT circular buffer with rd_ptr/wr_ptr of $clog2(FIFO_DEPTH)+1 bits (MSB is the wrap bit). Full when pointers differ only in the MSB; empty when equal.
- out_rd_en while out_empty: ignored, no pointer movement.
- Simultaneous stage-1 write and out_rd_en: both happen; out_count unchanged.
- Credits are not recycled combinationally. A pop in cycle N frees its credit for issue in cycle N+1.
- Reset, including mid-stream: in_rd_en = 0 in the same cycle. Next edge: stage-1 valid = 0, pointers = 0, out_count = 0, out_empty = 1, ovf = 0, out = 0. In-flight and buffered data are discarded. Issue may resume in the first cycle with reset low.
- State: the datapath needs no FSM; pipeline valid and pointer state define everything.

## Timing
- in_rd_en in cycle N → FIFO write at edge ending N+1 → out_empty falls, out/ovf valid in cycle N+2. Minimum latency is 2 cycles.
- Throughput is 1 vector/cycle while credits < FIFO_DEPTH.
- With FIFO_DEPTH entries buffered and no reads, in_rd_en holds 0. After one out_rd_en in cycle N, in_rd_en may assert in cycle N+1.
- out, ovf, out_empty and out_count are register/memory driven: no combinational path from inputs.
- in_rd_en is combinational from in_empty, reset and registered credit state only. It does not depend on out_rd_en.

## Configuration
- VEC_ADDSUB_SAT_EN defined: an overflowing lane is clamped to its signed limit, 2^(DATA_WIDTH−1)−1 on positive overflow and −2^(DATA_WIDTH−1) on negative overflow. ovf is still reported.
- Not defined: a lane result wraps modulo 2^DATA_WIDTH (plain two's complement). ovf is still reported.

## Test plan
- Reset then idle: out_empty=1, out=0, ovf=0, out_count=0, in_rd_en=0 while reset high.
- Single add, x={1,−2,100}, y={3,5,−100}, op=0: out={4,3,0}, ovf=0, out_empty falls 2 cycles after in_rd_en.
- Subtract with overflow, x[0]=0x7FFFFFFF, y[0]=−1, op=1: ovf=1. out[0]=0x80000000 without the macro, 0x7FFFFFFF with VEC_ADDSUB_SAT_EN.
- Back-to-back stream of 40 vectors, out_rd_en held 1: in_rd_en high every cycle after the first, results in order, out_count ≤ 2.
- Fill with out_rd_en=0: exactly FIFO_DEPTH pops then in_rd_en=0. One out_rd_en → exactly one further pop, the cycle after. Simultaneous push/pop keeps out_count constant.
- Reset asserted with 5 entries buffered and one in flight: out_empty=1 the next cycle, and no stale entry ever appears after reset releases.
